decoder_stack_ctrl: RTL and testbench

- Depth-first search sequencer that drives one decoder_stack instance to enumerate DNA base paths of length target_len, base by base.
- Each partial path goes to an external constraint checker; admissible full-length paths are streamed out under a valid/ready handshake.
- Sits between the stack, which is instantiated beside it at the same level, and the decoder's constraint and consumer logic.

---
 rtl/decoder_ctrl_pkg.sv | 35 +++
 rtl/decoder_stack_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_decoder_stack_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_ctrl_pkg.sv
// Shared types and helpers for the decoder stack sequencer: FSM states,
// DNA base codes and the stack tag layout (depth*4 + next_base).
package decoder_ctrl_pkg;

  localparam int LEN_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXPAND,
    S_CHECK,
    S_EMIT,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  function automatic logic [31:0] tag_pack(input logic [LEN_W-1:0] depth,
                                           input logic [1:0]       base);
    return {{(32-LEN_W-2){1'b0}}, depth, base};
  endfunction

  function automatic logic [LEN_W-1:0] tag_depth(input logic [LEN_W+1:0] tag);
    return tag[LEN_W+1:2];
  endfunction

  function automatic logic [1:0] tag_base(input logic [LEN_W+1:0] tag);
    return tag[1:0];
  endfunction

endpackage

// File: rtl/decoder_stack_ctrl.sv
// Depth-first path sequencer driving an external decoder_stack.
// Optional macro STACK_CTRL_PERF_EN adds perf_max_occ / perf_rejects outputs.
module decoder_stack_ctrl
  import decoder_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 16,
  parameter int MAX_LEN     = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      target_len,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  output logic [31:0]           stk_N_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic [31:0]           stk_N_out,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic                  chk_req,
  output logic [DATA_WIDTH-1:0] chk_path,
  output logic [LEN_W-1:0]      chk_len,
  input  logic                  chk_ack,
  input  logic                  chk_ok,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_path,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
`ifdef STACK_CTRL_PERF_EN
  output logic [15:0]           perf_max_occ,
  output logic [15:0]           perf_rejects,
`endif
  output logic [15:0]           n_found
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  state_t                r_state, w_next;
  logic [LEN_W-1:0]      r_tlen, r_depth;
  logic [1:0]            r_base;
  logic [DATA_WIDTH-1:0] r_path, r_cand;
  logic [15:0]           r_n_found;
  logic                  r_err, r_flush_done;

  logic                  w_push, w_pop, w_start, w_accept, w_reject, w_ovf, w_fd_set;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [31:0]           w_push_tag;
  logic [LEN_W-1:0]      w_tlen_clamp, w_depth_p1;
  logic                  w_unused;

  function automatic logic [DATA_WIDTH-1:0] set_base(input logic [DATA_WIDTH-1:0] p,
                                                     input logic [LEN_W-1:0]      d,
                                                     input logic [1:0]            b);
    logic [DATA_WIDTH-1:0] m;
    m = p;
    m[{d, 1'b0} +: 2] = b;
    return m;
  endfunction

  assign w_unused     = ^stk_N_out[31:LEN_W+2];
  assign w_depth_p1   = r_depth + ONE_L;
  assign w_tlen_clamp = (target_len == '0 || target_len > MAX_LEN_L) ? MAX_LEN_L : target_len;

  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = '0;
    w_push_tag  = '0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_ovf       = 1'b0;
    w_fd_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && rst_n) begin
          w_start = 1'b1;
          if (!stk_empty) begin
            w_next = S_FLUSH;
          end else begin
            w_push = 1'b1;
            w_next = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (stk_empty) begin
          w_next = S_DONE;
        end else begin
          w_pop  = 1'b1;
          w_next = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (r_base != BASE_T) begin
          w_push      = 1'b1;
          w_push_data = r_path;
          w_push_tag  = tag_pack(r_depth, r_base + 2'd1);
        end
        w_next = S_CHECK;
      end
      S_CHECK: begin
        if (chk_ack) begin
          if (!chk_ok) begin
            w_reject = 1'b1;
            w_next   = S_FETCH;
          end else if (w_depth_p1 == r_tlen) begin
            w_next = S_EMIT;
          end else begin
            w_push      = 1'b1;
            w_push_data = r_cand;
            w_push_tag  = tag_pack(w_depth_p1, BASE_A);
            w_next      = S_FETCH;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_accept = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_FLUSH: begin
        if (!stk_empty) begin
          w_pop = 1'b1;
        end else if (r_flush_done) begin
          w_next = S_DONE;
        end else begin
          w_push = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Abort overrides every other event; DONE is already terminating, so it completes.
    if (abort && r_state != S_IDLE && r_state != S_DONE) begin
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_accept = 1'b0;
      w_reject = 1'b0;
      w_next   = S_FLUSH;
      w_fd_set = 1'b1;
    end else if (w_push && stk_full) begin
      w_ovf    = 1'b1;
      w_next   = S_FLUSH;
      w_fd_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tlen       <= '0;
      r_depth      <= '0;
      r_base       <= '0;
      r_path       <= '0;
      r_cand       <= '0;
      r_n_found    <= '0;
      r_err        <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_tlen       <= w_tlen_clamp;
        r_n_found    <= '0;
        r_err        <= 1'b0;
        r_flush_done <= 1'b0;
      end
      if (w_fd_set) r_flush_done <= 1'b1;
      if (w_ovf)    r_err        <= 1'b1;
      if (r_state == S_FETCH && w_pop) begin
        r_path  <= stk_data_out;
        r_depth <= tag_depth(stk_N_out[LEN_W+1:0]);
        r_base  <= tag_base(stk_N_out[LEN_W+1:0]);
      end
      if (r_state == S_EXPAND) r_cand <= set_base(r_path, r_depth, r_base);
      if (w_accept && r_n_found != 16'hFFFF) r_n_found <= r_n_found + 16'd1;
    end
  end

  assign stk_push     = w_push;
  assign stk_pop      = w_pop;
  assign stk_data_in  = w_push_data;
  assign stk_N_in     = w_push_tag;
  assign chk_req      = (r_state == S_CHECK);
  assign chk_path     = chk_req ? r_cand : '0;
  assign chk_len      = chk_req ? w_depth_p1 : '0;
  assign out_valid    = (r_state == S_EMIT);
  assign out_path     = out_valid ? r_cand : '0;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err_overflow = r_err;
  assign n_found      = r_n_found;

`ifdef STACK_CTRL_PERF_EN
  localparam int OCC_W = $clog2(STACK_DEPTH + 1);

  logic [OCC_W-1:0] r_occ, w_occ_base, w_occ_next;
  logic [15:0]      r_max_occ, r_rejects, w_max_base, w_rej_base;

  // Occupancy is tracked from our own accepted push/pop, rebased to zero on start.
  always_comb begin
    w_occ_base = w_start ? '0 : r_occ;
    w_max_base = w_start ? '0 : r_max_occ;
    w_rej_base = w_start ? '0 : r_rejects;
    w_occ_next = w_occ_base;
    if (w_push && !stk_full)              w_occ_next = w_occ_base + 1'b1;
    else if (w_pop && w_occ_base != '0)   w_occ_next = w_occ_base - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ     <= '0;
      r_max_occ <= '0;
      r_rejects <= '0;
    end else begin
      r_occ     <= w_occ_next;
      r_max_occ <= (16'(w_occ_next) > w_max_base) ? 16'(w_occ_next) : w_max_base;
      r_rejects <= (w_reject && w_rej_base != 16'hFFFF) ? w_rej_base + 16'd1 : w_rej_base;
    end
  end

  assign perf_max_occ = r_max_occ;
  assign perf_rejects = r_rejects;
`endif

endmodule

// File: tb/tb_decoder_stack_ctrl.sv
// Scoreboard bench for decoder_stack_ctrl with behavioural stack, checker and consumer.
module tb_decoder_stack_ctrl;
  import decoder_ctrl_pkg::*;

  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, abort = 1'b0;
  logic [LEN_W-1:0] target_len = '0;
  logic             stk_push, stk_pop, stk_full, stk_empty;
  logic [DW-1:0]    stk_data_in, stk_data_out;
  logic [31:0]      stk_N_in, stk_N_out;
  logic             chk_req, chk_ack = 1'b0, chk_ok = 1'b0;
  logic [DW-1:0]    chk_path, out_path;
  logic [LEN_W-1:0] chk_len;
  logic             out_valid, out_ready = 1'b0;
  logic             busy, done, err_overflow;
  logic [15:0]      n_found;
`ifdef STACK_CTRL_PERF_EN
  logic [15:0]      perf_max_occ, perf_rejects;
`endif

  decoder_stack_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(16), .MAX_LEN(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target_len(target_len),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in), .stk_N_in(stk_N_in),
    .stk_data_out(stk_data_out), .stk_N_out(stk_N_out), .stk_full(stk_full),
    .stk_empty(stk_empty), .chk_req(chk_req), .chk_path(chk_path), .chk_len(chk_len),
    .chk_ack(chk_ack), .chk_ok(chk_ok), .out_valid(out_valid), .out_path(out_path),
    .out_ready(out_ready), .busy(busy), .done(done), .err_overflow(err_overflow),
`ifdef STACK_CTRL_PERF_EN
    .perf_max_occ(perf_max_occ), .perf_rejects(perf_rejects),
`endif
    .n_found(n_found)
  );

  always #5 clk = ~clk;

  // Behavioural stack with run-time capacity.
  logic [DW-1:0] mem_d [0:63];
  logic [31:0]   mem_n [0:63];
  int            sp = 0;
  int            cap = 64;
  assign stk_empty    = (sp == 0);
  assign stk_full     = (sp >= cap);
  assign stk_data_out = (sp > 0) ? mem_d[sp-1] : '0;
  assign stk_N_out    = (sp > 0) ? mem_n[sp-1] : '0;
  always @(posedge clk) begin
    if (stk_push && !stk_full) begin
      mem_d[sp] <= stk_data_in;
      mem_n[sp] <= stk_N_in;
      sp <= sp + 1;
    end else if (stk_pop && !stk_empty) begin
      sp <= sp - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int pushpop_bad = 0;
  int mode = 0;
  bit ack_en = 1'b1;
  int stall = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit model_ok(input logic [DW-1:0] p, input logic [LEN_W-1:0] len);
    int l;
    logic [1:0] nb, pb;
    l  = int'(len);
    nb = p[2*(l-1) +: 2];
    pb = (l >= 2) ? p[2*(l-2) +: 2] : 2'd0;
    case (mode)
      1:       return nb != BASE_G;
      2:       return !(l >= 2 && nb == pb);
      default: return 1'b1;
    endcase
  endfunction

  // Checker: acks in the first cycle of each request.
  initial forever begin
    @(negedge clk);
    chk_ack = 1'b0;
    chk_ok  = 1'b0;
    if (chk_req && ack_en) begin
      chk_ack = 1'b1;
      chk_ok  = model_ok(chk_path, chk_len);
    end
  end

  // Consumer with optional initial stall.
  initial forever begin
    @(negedge clk);
    if (out_valid && stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = out_valid;
    end
  end

  // Monitor: pops the scoreboard on each accept.
  initial forever begin
    @(negedge clk);
    #1;
    if (done) done_cnt++;
    if (stk_push && stk_pop) pushpop_bad++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        if (out_ready) check("unexpected_out", out_path, 64'hDEAD_BEEF_0000_0000);
      end else if (out_ready) begin
        check("nfound_pre", n_found, acc_cnt);
        check("out_path", out_path, exp_q.pop_front());
        acc_cnt++;
      end else begin
        check("stall_path", out_path, exp_q[0]);
        check("stall_nostack", {stk_push, stk_pop}, 0);
        check("stall_nfound", n_found, acc_cnt);
      end
    end
  end

  task automatic do_start(input int len);
    @(negedge clk);
    acc_cnt    = 0;
    target_len = LEN_W'(len);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c, d0;
    c  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    #2;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_idle"}, busy, 0);
    check({name, "_stack_empty"}, sp, 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] t1 [16];
    t1 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h1, 32'h5, 32'h9, 32'hD,
           32'h2, 32'h6, 32'hA, 32'hE, 32'h3, 32'h7, 32'hB, 32'hF};

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_outputs", {stk_push, stk_pop, chk_req, out_valid, done, err_overflow}, 0);
    check("rst_nfound", n_found, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full enumeration of length-2 paths.
    mode = 0;
    foreach (t1[i]) exp_q.push_back(t1[i]);
    do_start(2);
    wait_done("len2", 400);
    check("len2_nfound", n_found, 16);

    // Length 1, G rejected.
    mode = 1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h3);
    do_start(1);
    wait_done("len1_noG", 100);
    check("len1_noG_nfound", n_found, 3);

    // Length 3 without adjacent repeats.
    mode = 2;
    for (int b0 = 0; b0 < 4; b0++)
      for (int b1 = 0; b1 < 4; b1++)
        for (int b2 = 0; b2 < 4; b2++)
          if (b1 != b0 && b2 != b1) exp_q.push_back(DW'(b0 | (b1 << 2) | (b2 << 4)));
    check("len3_expected_count", exp_q.size(), 36);
    do_start(3);
    wait_done("len3_nohomo", 2000);
    check("len3_nfound", n_found, 36);

    // First output stalled for 5 cycles.
    mode  = 0;
    stall = 5;
    for (int b = 0; b < 4; b++) exp_q.push_back(DW'(b));
    do_start(1);
    wait_done("stall", 200);
    check("stall_nfound_final", n_found, 4);
    check("stall_consumed", stall, 0);

    // Overflow with a 4-entry stack.
    cap = 4;
    do_start(8);
    wait_done("ovf", 200);
    check("ovf_err", err_overflow, 1);
    check("ovf_nfound", n_found, 0);
    cap = 64;

    // Abort while waiting on the checker, then a clean restart.
    ack_en = 1'b0;
    do_start(3);
    begin
      int c;
      c = 0;
      while (!chk_req && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    check("abort_in_check", chk_req, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_req_dropped", chk_req, 0);
    check("abort_busy", busy, 1);
    wait_done("abort", 100);
    check("abort_err_clear", err_overflow, 0);
    ack_en = 1'b1;
    for (int b = 0; b < 4; b++) exp_q.push_back(DW'(b));
    do_start(1);
    wait_done("restart", 100);
    check("restart_nfound", n_found, 4);

    check("never_push_and_pop", pushpop_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
